theta_apply_controller: RTL and testbench

THETA_APPLY_CONTROLLER -- requirements
Module: theta_apply_controller

---
 rtl/theta_apply_controller.sv | 132 +++++++++++++
 tb/tb_theta_apply_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/theta_apply_controller.sv
// theta_apply_controller
//   Walks the 25 lanes of a Keccak-style state memory and applies the theta
//   column correction.
//
//   The per-column terms D[x] = C[x-1] ^ rotl1(C[x+1]) are captured once from
//   par_in at the start of a pass. Each lane is then read, XORed with D[x] and
//   written back in place.
//
//   Lane order is x-major: (0,0),(0,1)..(0,4),(1,0)..(4,4).
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     start      begin a pass (sampled in IDLE only)
//     par_in     column parities, C[x] = par_in[x*LANE_W +: LANE_W]
//     mem_x/y    lane index for the current access
//     mem_rd     read strobe; mem_rdata is valid the following cycle
//     mem_rdata  lane read data
//     mem_wr     write strobe at (mem_x, mem_y)
//     mem_wdata  lane write data
//     busy       high outside IDLE (only when THETA_BUSY_EN is defined)
//     finish     one-cycle completion pulse
//
//   Optional feature macro: THETA_BUSY_EN adds the busy output.
module theta_apply_controller #(
   parameter int unsigned LANE_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [5*LANE_W-1:0] par_in,
   output logic [2:0]          mem_x,
   output logic [2:0]          mem_y,
   output logic                mem_rd,
   input  logic [LANE_W-1:0]   mem_rdata,
   output logic                mem_wr,
   output logic [LANE_W-1:0]   mem_wdata,
`ifdef THETA_BUSY_EN
   output logic                busy,
`endif
   output logic                finish
);

   typedef enum logic [2:0] {
      StIdle, StInit, StRead, StWrite, StCheckY, StIncX, StCheckX, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        x_q, x_d;
   logic [2:0]        y_q, y_d;
   logic [LANE_W-1:0] d_q    [5];
   logic [LANE_W-1:0] d_calc [5];
   logic [LANE_W-1:0] d_sel;

   function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
      return {v[LANE_W-2:0], v[LANE_W-1]};
   endfunction

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         d_calc[i] = par_in[((i + 4) % 5) * LANE_W +: LANE_W]
                   ^ rotl1(par_in[((i + 1) % 5) * LANE_W +: LANE_W]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         for (int i = 0; i < 5; i++) d_q[i] <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         // D is frozen for the rest of the pass once captured.
         if (state_q == StInit) begin
            for (int i = 0; i < 5; i++) d_q[i] <= d_calc[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StInit;
         StInit: begin
            x_d     = '0;
            y_d     = '0;
            state_d = StRead;
         end
         StRead:   state_d = StWrite;
         StWrite: begin
            y_d     = (y_q == 3'd4) ? 3'd0 : y_q + 3'd1;
            state_d = StCheckY;
         end
         StCheckY: state_d = (y_q == 3'd0) ? StIncX : StRead;
         StIncX: begin
            x_d     = (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
            state_d = StCheckX;
         end
         StCheckX: state_d = (x_q == 3'd0) ? StDone : StRead;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      d_sel = d_q[0];
      case (x_q)
         3'd1:    d_sel = d_q[1];
         3'd2:    d_sel = d_q[2];
         3'd3:    d_sel = d_q[3];
         3'd4:    d_sel = d_q[4];
         default: d_sel = d_q[0];
      endcase
   end

   // Outputs decode from state only, so reset drops them without a clock edge.
   assign mem_x     = x_q;
   assign mem_y     = y_q;
   assign mem_rd    = (state_q == StRead);
   assign mem_wr    = (state_q == StWrite);
   assign mem_wdata = (state_q == StWrite) ? (mem_rdata ^ d_sel) : '0;
   assign finish    = (state_q == StDone);
`ifdef THETA_BUSY_EN
   assign busy      = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_theta_apply_controller.sv
module tb_theta_apply_controller;
   localparam int unsigned W = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [5*W-1:0] par_in;
   logic [2:0]     mem_x, mem_y;
   logic           mem_rd, mem_wr, finish;
   logic [W-1:0]   mem_rdata, mem_wdata;
`ifdef THETA_BUSY_EN
   logic           busy;
`endif

   theta_apply_controller #(.LANE_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .par_in    (par_in),
      .mem_x     (mem_x),
      .mem_y     (mem_y),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
`ifdef THETA_BUSY_EN
      .busy      (busy),
`endif
      .finish    (finish)
   );

   always #5 clk = ~clk;

   // State memory model with one-cycle read latency, write counter and
   // lane-order checker. clr presets A[x,y] = x*5+y and clears the counters.
   logic [W-1:0] mem [5][5];
   logic         clr = 1'b0;
   int           wr_cnt;
   int           order_err;
   int           fin_seen;

   always @(posedge clk) begin
      if (clr) begin
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) mem[x][y] <= W'(x * 5 + y);
         wr_cnt    <= 0;
         order_err <= 0;
         fin_seen  <= 0;
      end else begin
         if (mem_rd && mem_x < 5 && mem_y < 5) mem_rdata <= mem[mem_x][mem_y];
         if (mem_wr) begin
            if (mem_x < 5 && mem_y < 5) mem[mem_x][mem_y] <= mem_wdata;
            if (mem_x != 3'((wr_cnt % 25) / 5) || mem_y != 3'(wr_cnt % 5))
               order_err <= order_err + 1;
            wr_cnt <= wr_cnt + 1;
         end
         if (finish) fin_seen <= fin_seen + 1;
      end
   end

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic check_lanes(input string tag, input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic [W-1:0] d3,
                              input logic [W-1:0] d4);
      logic [W-1:0] dx [5];
      dx[0] = d0; dx[1] = d1; dx[2] = d2; dx[3] = d3; dx[4] = d4;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            check($sformatf("%s[%0d,%0d]", tag, x, y), mem[x][y], W'(x * 5 + y) ^ dx[x]);
   endtask

   // Edge 1 is the edge that samples start. Start is re-driven for pulse_a/b,
   // or held through edge 170 when hold is set. scramble changes par_in mid-pass.
   task automatic run_pass(input int pulse_a, input int pulse_b, input bit hold,
                           input bit scramble, input int last_edge,
                           output int fin_first, output int fin_second, output int fin_cnt);
      fin_first  = -1;
      fin_second = -1;
      fin_cnt    = 0;
      @(negedge clk); start = 1'b1;
      for (int e = 1; e <= last_edge; e++) begin
         @(posedge clk); #1;
         if (finish) begin
            fin_cnt++;
            if (fin_first < 0) fin_first = e;
            else if (fin_second < 0) fin_second = e;
         end
`ifdef THETA_BUSY_EN
         if (e == 1) check("busy_init", W'(busy), W'(1));
         if (!hold && e == 87) check("busy_done", W'(busy), W'(1));
         if (!hold && e == 88) check("busy_idle", W'(busy), W'(0));
`endif
         if (scramble && e == 5) par_in = {$urandom, $urandom, $urandom, $urandom, $urandom,
                                           $urandom, $urandom, $urandom, $urandom, $urandom};
         start = (hold && e + 1 <= 170) || (e + 1 == pulse_a) || (e + 1 == pulse_b);
      end
      start = 1'b0;
   endtask

   int f1, f2, fc;
   logic [W-1:0] msb;

   initial begin
      msb    = {1'b1, {(W - 1){1'b0}}};
      rst    = 1'b0;
      start  = 1'b0;
      par_in = '0;
      repeat (2) @(negedge clk);
      check("rst_rd", W'(mem_rd), W'(0));
      check("rst_wr", W'(mem_wr), W'(0));
      check("rst_finish", W'(finish), W'(0));
      check("rst_wdata", mem_wdata, W'(0));
      check("rst_xy", W'({mem_x, mem_y}), W'(0));
`ifdef THETA_BUSY_EN
      check("rst_busy", W'(busy), W'(0));
`endif
      rst = 1'b1;
      do_clr();

      // Zero parity: memory unchanged.
      run_pass(0, 0, 1'b0, 1'b0, 100, f1, f2, fc);
      check("p0_fin_edge", W'(f1), W'(87));
      check("p0_fin_cnt", W'(fc), W'(1));
      check("p0_writes", W'(wr_cnt), W'(25));
      check("p0_order", W'(order_err), W'(0));
      check_lanes("p0", 0, 0, 0, 0, 0);

      // C[1]=1 -> D[0]=2, D[2]=1; par_in scrambled mid-pass must be ignored.
      do_clr();
      par_in = '0;
      par_in[1*W +: W] = W'(1);
      run_pass(0, 0, 1'b0, 1'b1, 100, f1, f2, fc);
      check("c1_fin_edge", W'(f1), W'(87));
      check_lanes("c1", W'(2), 0, W'(1), 0, 0);

      // C[4]=msb -> D[0]=msb, D[3]=1 (rotate carry).
      do_clr();
      par_in = '0;
      par_in[4*W +: W] = msb;
      run_pass(0, 0, 1'b0, 1'b0, 100, f1, f2, fc);
      check("c4_writes", W'(wr_cnt), W'(25));
      check_lanes("c4", msb, 0, 0, W'(1), 0);

      // Start re-pulsed mid-pass is ignored.
      do_clr();
      par_in = '0;
      run_pass(10, 50, 1'b0, 1'b0, 100, f1, f2, fc);
      check("rs_fin_edge", W'(f1), W'(87));
      check("rs_fin_cnt", W'(fc), W'(1));
      repeat (10) @(negedge clk);
      check("rs_writes", W'(wr_cnt), W'(25));
      check("rs_idle_rd", W'(mem_rd), W'(0));

      // Reset mid-pass at edge 40 (lane (2,1) in WRITE).
      do_clr();
      run_pass(0, 0, 1'b0, 1'b0, 40, f1, f2, fc);
      check("mr_pre_wr", W'(mem_wr), W'(1));
      rst = 1'b0;
      #1;
      check("mr_wr", W'(mem_wr), W'(0));
      check("mr_rd", W'(mem_rd), W'(0));
      check("mr_finish", W'(finish), W'(0));
      check("mr_wdata", mem_wdata, W'(0));
      check("mr_xy", W'({mem_x, mem_y}), W'(0));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("mr_writes", W'(wr_cnt), W'(11));
      check("mr_no_fin", W'(fin_seen), W'(0));
      check("mr_idle_rd", W'(mem_rd), W'(0));
      do_clr();
      run_pass(0, 0, 1'b0, 1'b0, 100, f1, f2, fc);
      check("mr_new_fin", W'(f1), W'(87));
      check("mr_new_writes", W'(wr_cnt), W'(25));

      // Start held high: back-to-back passes, one IDLE cycle between.
      do_clr();
      run_pass(0, 0, 1'b1, 1'b0, 180, f1, f2, fc);
      check("bb_fin1", W'(f1), W'(87));
      check("bb_fin2", W'(f2), W'(175));
      check("bb_fin_cnt", W'(fc), W'(2));
      check("bb_writes", W'(wr_cnt), W'(50));
      check("bb_order", W'(order_err), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
